player_status_tracker: RTL and testbench

//  Per-player damage, stock, hitstun and respawn tracker for N players, with match-end detection.
//  Fed by collision/KO logic (got_hit, offscreen); drives top_states, HUD and game-flow control.

---
 rtl/smash_pkg.sv | 28 ++
 rtl/player_status_tracker_if.sv | 47 ++++
 rtl/player_status_lane.sv | 139 +++++++++++++
 rtl/player_status_tracker.sv | 105 ++++++++++
 tb/tb_player_status_tracker.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/smash_pkg.sv
// ---------------------------------------------------------------------------
// smash_pkg
// Shared types and widths for the player status tracker.
//   player_state_t : per-player lifecycle state
//   DAMAGE_W       : width of the percent-damage counter
//   TIMER_W        : width of the per-player frame timer
//   HIT_W          : width of one hit's damage value
//   win_w()        : width of a player index (at least one bit)
// ---------------------------------------------------------------------------
package smash_pkg;

  typedef enum logic [2:0] {
    ALIVE,
    HITSTUN,
    RESPAWN,
    INVULN,
    OUT
  } player_state_t;

  localparam int DAMAGE_W = 10;
  localparam int TIMER_W  = 8;
  localparam int HIT_W    = 6;

  function automatic int win_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/player_status_tracker_if.sv
// ---------------------------------------------------------------------------
// player_status_tracker_if
// Bundles the game-logic side of the tracker.
//   master : collision/KO logic and game flow (drives events, reads status)
//   slave  : the tracker (reads events, drives status)
// Event signals : frame_tick, got_hit, hit_damage_in, offscreen
// Status signals: hit_stun_active, can_grab_ledge, invulnerable,
//                 respawn_pending, player_out, damage, stocks,
//                 game_over, winner, draw
// ---------------------------------------------------------------------------
interface player_status_tracker_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int STOCK_W     = 2
);
  import smash_pkg::*;

  localparam int WIN_W = win_w(NUM_PLAYERS);

  logic                                    frame_tick;
  logic [NUM_PLAYERS-1:0]                  got_hit;
  logic [NUM_PLAYERS-1:0][HIT_W-1:0]       hit_damage_in;
  logic [NUM_PLAYERS-1:0]                  offscreen;

  logic [NUM_PLAYERS-1:0]                  hit_stun_active;
  logic [NUM_PLAYERS-1:0]                  can_grab_ledge;
  logic [NUM_PLAYERS-1:0]                  invulnerable;
  logic [NUM_PLAYERS-1:0]                  respawn_pending;
  logic [NUM_PLAYERS-1:0]                  player_out;
  logic [NUM_PLAYERS-1:0][DAMAGE_W-1:0]    damage;
  logic [NUM_PLAYERS-1:0][STOCK_W-1:0]     stocks;
  logic                                    game_over;
  logic [WIN_W-1:0]                        winner;
  logic                                    draw;

  modport master (
    output frame_tick, got_hit, hit_damage_in, offscreen,
    input  hit_stun_active, can_grab_ledge, invulnerable, respawn_pending,
           player_out, damage, stocks, game_over, winner, draw
  );

  modport slave (
    input  frame_tick, got_hit, hit_damage_in, offscreen,
    output hit_stun_active, can_grab_ledge, invulnerable, respawn_pending,
           player_out, damage, stocks, game_over, winner, draw
  );

endinterface

// File: rtl/player_status_lane.sv
// ---------------------------------------------------------------------------
// player_status_lane
// State, damage, stocks and frame timer for one player.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   frame_tick_i        one-cycle pulse per video frame
//   got_hit_i           hit event for this player
//   hit_damage_i        damage carried by the hit
//   offscreen_i         blast-zone (KO) event for this player
//   freeze_i            match over: ignore hit/KO events, timers keep running
//   *_o status flags    decoded from the registered state
//   damage_o, stocks_o  registered damage and stock count
//   stocks_next_o       next-state stock count, for same-edge match-end logic
// ---------------------------------------------------------------------------
module player_status_lane
  import smash_pkg::*;
#(
  parameter int MAX_DAMAGE     = 999,
  parameter int START_STOCKS   = 3,
  parameter int STOCK_W        = 2,
  parameter int HITSTUN_BASE   = 10,
  parameter int HITSTUN_SHIFT  = 4,
  parameter int HITSTUN_MAX    = 60,
  parameter int RESPAWN_FRAMES = 90,
  parameter int INVULN_FRAMES  = 120
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick_i,
  input  logic                got_hit_i,
  input  logic [HIT_W-1:0]    hit_damage_i,
  input  logic                offscreen_i,
  input  logic                freeze_i,
  output logic                hit_stun_active_o,
  output logic                can_grab_ledge_o,
  output logic                invulnerable_o,
  output logic                respawn_pending_o,
  output logic                player_out_o,
  output logic [DAMAGE_W-1:0] damage_o,
  output logic [STOCK_W-1:0]  stocks_o,
  output logic [STOCK_W-1:0]  stocks_next_o
);

  // One extra bit so damage + hit cannot wrap before saturation.
  localparam int SUM_W = DAMAGE_W + 1;
  localparam logic [SUM_W-1:0] MAX_DMG = SUM_W'(MAX_DAMAGE);

  player_state_t         state_q, state_d;
  logic [DAMAGE_W-1:0]   damage_q, damage_d;
  logic [STOCK_W-1:0]    stocks_q, stocks_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;

  logic [SUM_W-1:0]      dmg_sum;
  logic [SUM_W-1:0]      dmg_hit;
  logic [SUM_W-1:0]      stun_raw;
  logic [TIMER_W-1:0]    stun_hit;
  logic                  expire;
  logic                  ko;
  logic                  hit;

  // Damage and hitstun a hit would produce; stun scales with post-hit damage.
  always_comb begin
    dmg_sum  = SUM_W'(damage_q) + SUM_W'(hit_damage_i);
    dmg_hit  = (dmg_sum > MAX_DMG) ? MAX_DMG : dmg_sum;
    stun_raw = SUM_W'(HITSTUN_BASE) + (dmg_hit >> HITSTUN_SHIFT);
    stun_hit = (stun_raw > SUM_W'(HITSTUN_MAX)) ? TIMER_W'(HITSTUN_MAX)
                                                : stun_raw[TIMER_W-1:0];
  end

  // Timed phases end on the tick that takes the timer from 1 to 0.
  assign expire = frame_tick_i && (timer_q == TIMER_W'(1));
  assign ko     = offscreen_i && !freeze_i && (state_q inside {ALIVE, HITSTUN, INVULN});
  assign hit    = got_hit_i && !freeze_i && (state_q inside {ALIVE, HITSTUN});

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no branch
    // below can leave one unassigned and infer a latch.
    state_d  = state_q;
    damage_d = damage_q;
    stocks_d = stocks_q;
    timer_d  = timer_q;

    if (frame_tick_i && (timer_q != '0)) begin
      timer_d = timer_q - TIMER_W'(1);
    end

    unique case (state_q)
      HITSTUN: if (expire) state_d = ALIVE;
      RESPAWN: if (expire) begin
        state_d = INVULN;
        timer_d = TIMER_W'(INVULN_FRAMES);
      end
      INVULN:  if (expire) state_d = ALIVE;
      default: ;
    endcase

    // A KO outranks a hit in the same cycle; the hit is discarded.
    if (ko) begin
      stocks_d = stocks_q - STOCK_W'(1);
      damage_d = '0;
      if (stocks_d == '0) begin
        state_d = OUT;
      end else begin
        state_d = RESPAWN;
        timer_d = TIMER_W'(RESPAWN_FRAMES);
      end
    end else if (hit) begin
      damage_d = dmg_hit[DAMAGE_W-1:0];
      timer_d  = stun_hit;
      state_d  = HITSTUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ALIVE;
      damage_q <= '0;
      stocks_q <= STOCK_W'(START_STOCKS);
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      damage_q <= damage_d;
      stocks_q <= stocks_d;
      timer_q  <= timer_d;
    end
  end

  assign hit_stun_active_o = (state_q == HITSTUN);
  assign can_grab_ledge_o  = (state_q == ALIVE) || (state_q == INVULN);
  assign invulnerable_o    = (state_q == INVULN);
  assign respawn_pending_o = (state_q == RESPAWN);
  assign player_out_o      = (state_q == OUT);
  assign damage_o          = damage_q;
  assign stocks_o          = stocks_q;
  assign stocks_next_o     = stocks_d;

endmodule

// File: rtl/player_status_tracker.sv
// ---------------------------------------------------------------------------
// player_status_tracker
// Per-player damage/stock/hitstun/respawn tracking with match-end detection.
// Ports:
//   clk       system clock
//   reset_n   asynchronous reset, active-low
//   bus       player_status_tracker_if.slave: hit/KO events and frame tick
//             in, per-player status plus game_over/winner/draw out
// One player_status_lane per player; this level owns the survivor count,
// winner priority encoder and the sticky game_over/winner/draw registers.
// ---------------------------------------------------------------------------
module player_status_tracker
  import smash_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int MAX_DAMAGE     = 999,
  parameter int START_STOCKS   = 3,
  parameter int STOCK_W        = 2,
  parameter int HITSTUN_BASE   = 10,
  parameter int HITSTUN_SHIFT  = 4,
  parameter int HITSTUN_MAX    = 60,
  parameter int RESPAWN_FRAMES = 90,
  parameter int INVULN_FRAMES  = 120
) (
  input  logic                   clk,
  input  logic                   reset_n,
  player_status_tracker_if.slave bus
);

  localparam int WIN_W = win_w(NUM_PLAYERS);

  logic [NUM_PLAYERS-1:0][STOCK_W-1:0] stocks_next;
  logic                                game_over_q, game_over_d;
  logic                                draw_q, draw_d;
  logic [WIN_W-1:0]                    winner_q, winner_d;
  logic [WIN_W-1:0]                    first_idx;
  int unsigned                         survivors;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    player_status_lane #(
      .MAX_DAMAGE     (MAX_DAMAGE),
      .START_STOCKS   (START_STOCKS),
      .STOCK_W        (STOCK_W),
      .HITSTUN_BASE   (HITSTUN_BASE),
      .HITSTUN_SHIFT  (HITSTUN_SHIFT),
      .HITSTUN_MAX    (HITSTUN_MAX),
      .RESPAWN_FRAMES (RESPAWN_FRAMES),
      .INVULN_FRAMES  (INVULN_FRAMES)
    ) u_lane (
      .clk               (clk),
      .reset_n           (reset_n),
      .frame_tick_i      (bus.frame_tick),
      .got_hit_i         (bus.got_hit[i]),
      .hit_damage_i      (bus.hit_damage_in[i]),
      .offscreen_i       (bus.offscreen[i]),
      .freeze_i          (game_over_q),
      .hit_stun_active_o (bus.hit_stun_active[i]),
      .can_grab_ledge_o  (bus.can_grab_ledge[i]),
      .invulnerable_o    (bus.invulnerable[i]),
      .respawn_pending_o (bus.respawn_pending[i]),
      .player_out_o      (bus.player_out[i]),
      .damage_o          (bus.damage[i]),
      .stocks_o          (bus.stocks[i]),
      .stocks_next_o     (stocks_next[i])
    );
  end

  // Match end looks at next-state stocks so game_over lands on the same edge
  // as the deciding KO. Scanning downward leaves the lowest survivor index.
  always_comb begin
    survivors   = 0;
    first_idx   = '0;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (stocks_next[i] != '0) begin
        survivors = survivors + 1;
        first_idx = WIN_W'(i);
      end
    end
    if (!game_over_q && (survivors <= 1)) begin
      game_over_d = 1'b1;
      winner_d    = first_idx;
      draw_d      = (survivors == 0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      game_over_q <= 1'b0;
      winner_q    <= '0;
      draw_q      <= 1'b0;
    end else begin
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      draw_q      <= draw_d;
    end
  end

  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.draw      = draw_q;

endmodule

// File: tb/tb_player_status_tracker.sv
// ---------------------------------------------------------------------------
// tb_player_status_tracker
// Directed scenarios followed by random matches, every cycle compared with a
// reference model that tracks each player as stocks/damage plus separate
// countdowns for stun, respawn and invulnerability.
// ---------------------------------------------------------------------------
module tb_player_status_tracker;
  import smash_pkg::*;

  localparam int N     = 2;
  localparam int SW    = 2;
  localparam int MAXD  = 999;
  localparam int START = 3;
  localparam int BASE  = 10;
  localparam int SHIFT = 4;
  localparam int SMAX  = 60;
  localparam int RESP  = 90;
  localparam int INV   = 120;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  player_status_tracker_if #(.NUM_PLAYERS(N), .STOCK_W(SW)) bus ();

  player_status_tracker #(
    .NUM_PLAYERS    (N),
    .MAX_DAMAGE     (MAXD),
    .START_STOCKS   (START),
    .STOCK_W        (SW),
    .HITSTUN_BASE   (BASE),
    .HITSTUN_SHIFT  (SHIFT),
    .HITSTUN_MAX    (SMAX),
    .RESPAWN_FRAMES (RESP),
    .INVULN_FRAMES  (INV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // Reference model: countdowns per phase instead of a state register.
  int m_dmg  [N];
  int m_stk  [N];
  int m_stun [N];
  int m_resp [N];
  int m_inv  [N];
  bit m_over;
  bit m_draw;
  int m_win;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_dmg[p]  = 0;
      m_stk[p]  = START;
      m_stun[p] = 0;
      m_resp[p] = 0;
      m_inv[p]  = 0;
    end
    m_over = 0;
    m_draw = 0;
    m_win  = 0;
  endtask

  // Applies one clock edge worth of rules using the inputs currently driven.
  task automatic model_apply();
    int left;
    int first;
    for (int p = 0; p < N; p++) begin
      bit in_play;
      bit ko_ok;
      bit hit_ok;
      in_play = (m_stk[p] != 0) && (m_resp[p] == 0) && (m_inv[p] == 0);
      ko_ok   = !m_over && bus.offscreen[p] && (m_stk[p] != 0) && (m_resp[p] == 0);
      hit_ok  = !m_over && bus.got_hit[p] && in_play && !ko_ok;
      if (bus.frame_tick) begin
        if (m_resp[p] > 0) begin
          m_resp[p]--;
          if (m_resp[p] == 0) m_inv[p] = INV;
        end else if (m_inv[p] > 0) begin
          m_inv[p]--;
        end else if (m_stun[p] > 0) begin
          m_stun[p]--;
        end
      end
      if (ko_ok) begin
        m_stk[p]--;
        m_dmg[p]  = 0;
        m_stun[p] = 0;
        m_inv[p]  = 0;
        m_resp[p] = (m_stk[p] != 0) ? RESP : 0;
      end else if (hit_ok) begin
        m_dmg[p]  = m_dmg[p] + int'(bus.hit_damage_in[p]);
        if (m_dmg[p] > MAXD) m_dmg[p] = MAXD;
        m_stun[p] = BASE + m_dmg[p] / (1 << SHIFT);
        if (m_stun[p] > SMAX) m_stun[p] = SMAX;
      end
    end
    if (!m_over) begin
      left  = 0;
      first = -1;
      for (int p = 0; p < N; p++) begin
        if (m_stk[p] != 0) begin
          left++;
          if (first < 0) first = p;
        end
      end
      if (left <= 1) begin
        m_over = 1;
        m_draw = (left == 0);
        m_win  = (left == 0) ? 0 : first;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_stun, e_grab, e_inv, e_resp, e_out;
    for (int p = 0; p < N; p++) begin
      e_stun[p] = (m_stun[p] > 0);
      e_grab[p] = (m_stk[p] != 0) && (m_resp[p] == 0) && (m_stun[p] == 0);
      e_inv[p]  = (m_inv[p] > 0);
      e_resp[p] = (m_resp[p] > 0);
      e_out[p]  = (m_stk[p] == 0);
    end
    check("hit_stun_active", 32'(bus.hit_stun_active), 32'(e_stun));
    check("can_grab_ledge",  32'(bus.can_grab_ledge),  32'(e_grab));
    check("invulnerable",    32'(bus.invulnerable),    32'(e_inv));
    check("respawn_pending", 32'(bus.respawn_pending), 32'(e_resp));
    check("player_out",      32'(bus.player_out),      32'(e_out));
    for (int p = 0; p < N; p++) begin
      check($sformatf("damage%0d", p), 32'(bus.damage[p]), 32'(m_dmg[p]));
      check($sformatf("stocks%0d", p), 32'(bus.stocks[p]), 32'(m_stk[p]));
    end
    check("game_over", 32'(bus.game_over), 32'(m_over));
    check("winner",    32'(bus.winner),    32'(m_win));
    check("draw",      32'(bus.draw),      32'(m_draw));
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, compare.
  task automatic step(input bit tick, input logic [N-1:0] hit, input logic [N-1:0] off,
                      input int d0, input int d1);
    bus.frame_tick       = tick;
    bus.got_hit          = hit;
    bus.offscreen        = off;
    bus.hit_damage_in[0] = 6'(d0);
    bus.hit_damage_in[1] = 6'(d1);
    @(posedge clk);
    model_apply();
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.got_hit    = '0;
    bus.offscreen  = '0;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, '0, '0, 0, 0);
  endtask

  // Reset lands between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    bus.frame_tick    = 1'b0;
    bus.got_hit       = '0;
    bus.offscreen     = '0;
    bus.hit_damage_in = '0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.frame_tick    = 1'b0;
    bus.got_hit       = '0;
    bus.offscreen     = '0;
    bus.hit_damage_in = '0;
    @(negedge clk);

    // 1. reset values
    phase = "reset";
    do_reset();
    check("stocks0_init", 32'(bus.stocks[0]), 32'd3);
    check("can_grab_init", 32'(bus.can_grab_ledge), 32'd3);
    step(1'b1, '0, '0, 0, 0);

    // 2. basic hit and 11-frame stun
    phase = "hit20";
    step(1'b0, 2'b01, 2'b00, 20, 0);
    check("dmg20", 32'(bus.damage[0]), 32'd20);
    check("stun_on", 32'(bus.hit_stun_active[0]), 32'd1);
    ticks(10);
    check("stun_tick10", 32'(bus.hit_stun_active[0]), 32'd1);
    ticks(1);
    check("stun_tick11", 32'(bus.hit_stun_active[0]), 32'd0);

    // 3. damage saturation, stun clamp, combo reload
    phase = "saturate";
    do_reset();
    repeat (15) step(1'b0, 2'b01, 2'b00, 63, 0);
    step(1'b0, 2'b01, 2'b00, 45, 0);
    check("dmg990", 32'(bus.damage[0]), 32'd990);
    step(1'b0, 2'b01, 2'b00, 30, 0);
    check("dmg999", 32'(bus.damage[0]), 32'd999);
    ticks(5);
    step(1'b0, 2'b01, 2'b00, 1, 0);
    ticks(59);
    check("combo_tick59", 32'(bus.hit_stun_active[0]), 32'd1);
    ticks(1);
    check("combo_tick60", 32'(bus.hit_stun_active[0]), 32'd0);

    // 4. KO, respawn delay, invulnerability; hits ignored in both phases
    phase = "respawn";
    do_reset();
    step(1'b0, 2'b10, 2'b00, 0, 33);
    step(1'b0, 2'b00, 2'b10, 0, 0);
    check("stocks1_ko", 32'(bus.stocks[1]), 32'd2);
    check("dmg1_ko", 32'(bus.damage[1]), 32'd0);
    step(1'b0, 2'b10, 2'b00, 0, 15);
    ticks(89);
    check("resp_tick89", 32'(bus.respawn_pending[1]), 32'd1);
    ticks(1);
    check("inv_tick90", 32'(bus.invulnerable[1]), 32'd1);
    step(1'b0, 2'b10, 2'b00, 0, 20);
    ticks(119);
    check("inv_tick119", 32'(bus.invulnerable[1]), 32'd1);
    ticks(1);
    check("alive_tick120", 32'(bus.can_grab_ledge[1]), 32'd1);
    check("dmg1_after", 32'(bus.damage[1]), 32'd0);

    // 5. hit and KO together: KO only
    phase = "hit_and_ko";
    do_reset();
    step(1'b0, 2'b01, 2'b00, 40, 0);
    step(1'b0, 2'b01, 2'b01, 25, 0);
    check("dmg0_zero", 32'(bus.damage[0]), 32'd0);
    check("stocks0_two", 32'(bus.stocks[0]), 32'd2);

    // 6. simultaneous last KOs: draw
    phase = "draw";
    do_reset();
    step(1'b0, 2'b00, 2'b11, 0, 0);
    ticks(90);
    step(1'b0, 2'b00, 2'b11, 0, 0);
    ticks(90);
    check("stocks_one", 32'(bus.stocks), 32'b0101);
    step(1'b0, 2'b00, 2'b11, 0, 0);
    check("out_both", 32'(bus.player_out), 32'b11);
    check("over_set", 32'(bus.game_over), 32'd1);
    check("draw_set", 32'(bus.draw), 32'd1);
    step(1'b1, 2'b11, 2'b11, 20, 20);
    ticks(5);
    do_reset();
    check("over_clear", 32'(bus.game_over), 32'd0);

    // 7. single survivor wins
    phase = "winner";
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b00, 2'b01, 0, 0);
      if (k < 2) ticks(90);
    end
    check("winner_p1", 32'(bus.winner), 32'd1);
    check("no_draw", 32'(bus.draw), 32'd0);
    step(1'b0, 2'b10, 2'b10, 0, 30);
    check("frozen_stocks1", 32'(bus.stocks[1]), 32'd3);

    // Reset in the middle of stun and respawn
    phase = "mid_reset";
    do_reset();
    step(1'b0, 2'b01, 2'b10, 50, 0);
    ticks(3);
    do_reset();

    // Random matches
    for (int m = 0; m < 6; m++) begin
      int after;
      phase = $sformatf("random%0d", m);
      do_reset();
      after = 0;
      for (int c = 0; c < 3000; c++) begin
        logic [N-1:0] h, o;
        for (int p = 0; p < N; p++) begin
          h[p] = ($urandom_range(0, 7) == 0);
          o[p] = ($urandom_range(0, 59) == 0);
        end
        step(1'($urandom_range(0, 1)), h, o,
             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        if (m_over) after++;
        if (after > 20) break;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
